// File: rtl/dma_timing_control_pkg.sv
// Shared encodings for the 8237A transfer-timing block (states, transfer type, mode).
// Constants only; no latency.
// No flow control; used by the timing FSM and the strobe decoder.
package dma_timing_control_pkg;

   localparam int NUM_CH = 4;
   localparam int CH_W   = 2;

   // Transfer-state encoding, kept as plain constants so legacy code can share it
   localparam logic [2:0] SI = 3'd0;
   localparam logic [2:0] S0 = 3'd1;
   localparam logic [2:0] S1 = 3'd2;
   localparam logic [2:0] S2 = 3'd3;
   localparam logic [2:0] S3 = 3'd4;
   localparam logic [2:0] SW = 3'd5;
   localparam logic [2:0] S4 = 3'd6;

   typedef logic [2:0] stateT;

   // Mode-register transfer type; 2'b11 is illegal and behaves as verify
   typedef enum logic [1:0] {
      VERIFY = 2'b00,
      WRITE  = 2'b01,
      READ   = 2'b10
   } xferTypeT;

   // Mode-register mode; cascade behaves as single here
   typedef enum logic [1:0] {
      DEMAND  = 2'b00,
      SINGLE  = 2'b01,
      BLOCK   = 2'b10,
      CASCADE = 2'b11
   } xferModeT;

   // True while the controller owns the bus for a transfer cycle
   function automatic logic inXfer(input stateT st);
      return (st == S1) || (st == S2) || (st == S3) || (st == SW) || (st == S4);
   endfunction

endpackage

// File: rtl/dma_strobe_decode.sv
// Maps a transfer state and transfer type to the four active-low command strobes.
// Purely combinational; zero latency (the caller registers the result).
// No flow control; READY stretching is handled by the caller holding SW.
module dma_strobe_decode
   import dma_timing_control_pkg::*;
#(
   parameter bit EXTENDED_WRITE = 1'b0
) (
   input  logic [2:0] state,
   input  logic [1:0] xferType,
   output logic       memrN,
   output logic       memwN,
   output logic       iorN,
   output logic       iowN
);

   logic rdPhase;
   logic wrPhase;

   // Read strobe covers S2..SW; write strobe covers S3..SW, or S2..SW when extended
   always_comb begin
      rdPhase = (state == S2) || (state == S3) || (state == SW);
      wrPhase = (state == S3) || (state == SW) || ((state == S2) && EXTENDED_WRITE);
      memrN   = 1'b1;
      memwN   = 1'b1;
      iorN    = 1'b1;
      iowN    = 1'b1;
      if (xferType == READ) begin
         // memory -> I/O
         memrN = !rdPhase;
         iowN  = !wrPhase;
      end else if (xferType == WRITE) begin
         // I/O -> memory
         iorN  = !rdPhase;
         memwN = !wrPhase;
      end
      // verify and the illegal code run full timing with no strobes
   end

endmodule

// File: rtl/dma_timing_control.sv
// 8237A transfer timing: HRQ/HLDA handshake and SI/S0/S1/S2/S3/SW/S4 sequencing.
// All outputs registered; they change on the edge that enters each state (HRQ one cycle after request).
// READY low holds the cycle in SW; HLDA gates bus ownership; EOP/TC end the service after S4.
module dma_timing_control #(
   parameter int NUM_CH         = 4,
   parameter int CH_W           = 2,
   parameter bit EXTENDED_WRITE = 1'b0
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              validDREQ,
   input  logic [CH_W-1:0]   grantCh,
   input  logic [1:0]        xferType,
   input  logic [1:0]        xferMode,
   input  logic              autoInit,
   input  logic              HLDA,
   input  logic              READY,
   input  logic              EOP_n,
   input  logic              lastXfer,
   output logic              HRQ,
   output logic [NUM_CH-1:0] DACK,
   output logic              AEN,
   output logic              ADSTB,
   output logic              MEMR_n,
   output logic              MEMW_n,
   output logic              IOR_n,
   output logic              IOW_n,
   output logic              addrUpdate,
   output logic              TC,
   output logic              reloadReq,
   output logic [CH_W-1:0]   activeCh
);

   import dma_timing_control_pkg::*;

   stateT             state;
   stateT             stateNxt;
   logic [1:0]        typeQ;
   logic [1:0]        typeNxt;
   logic [1:0]        modeQ;
   logic [1:0]        modeNxt;
   logic              autoQ;
   logic              autoNxt;
   logic [CH_W-1:0]   chNxt;
   logic              eopSeen;
   logic              eopNxt;
   logic              hldaLost;
   logic              hldaNxt;
   logic              endFlag;
   logic              xferNxt;
   logic [NUM_CH-1:0] dackNxt;
   logic              memrNxt;
   logic              memwNxt;
   logic              iorNxt;
   logic              iowNxt;

   // Next-state, channel latching and end-of-service bookkeeping
   always_comb begin
      stateNxt = state;
      chNxt    = activeCh;
      typeNxt  = typeQ;
      modeNxt  = modeQ;
      autoNxt  = autoQ;
      eopNxt   = eopSeen;
      hldaNxt  = hldaLost;
      // TC is high only while in S4, so it doubles as "this was the last word"
      endFlag  = TC || eopSeen || !EOP_n;

      case (state)
         SI: begin
            if (validDREQ) stateNxt = S0;
         end
         S0: begin
            if (HLDA) begin
               // the channel and its mode are frozen here for the whole service
               stateNxt = S1;
               chNxt    = grantCh;
               typeNxt  = xferType;
               modeNxt  = xferMode;
               autoNxt  = autoInit;
            end else if (!validDREQ) begin
               stateNxt = SI;
            end
         end
         S1: stateNxt = S2;
         S2: stateNxt = S3;
         S3, SW: stateNxt = READY ? S4 : SW;
         S4: begin
            if (endFlag || hldaLost || !HLDA) begin
               stateNxt = SI;
            end else if (modeQ == BLOCK) begin
               stateNxt = S1;
            end else if ((modeQ == DEMAND) && validDREQ && (grantCh == activeCh)) begin
               stateNxt = S1;
            end else begin
               stateNxt = SI;
            end
         end
         default: stateNxt = SI;
      endcase

      // EOP and a lost HLDA are remembered so the cycle can finish before acting on them
      if ((state == S1) || (state == S2) || (state == S3) || (state == SW)) begin
         if (!EOP_n) eopNxt  = 1'b1;
         if (!HLDA)  hldaNxt = 1'b1;
      end
      if (stateNxt == SI) begin
         eopNxt  = 1'b0;
         hldaNxt = 1'b0;
      end
   end

   // Output values for the state being entered
   always_comb begin
      xferNxt = inXfer(stateNxt);
      dackNxt = '0;
      if (xferNxt) dackNxt[chNxt] = 1'b1;
   end

   dma_strobe_decode #(
      .EXTENDED_WRITE (EXTENDED_WRITE)
   ) uStrobe (
      .state    (stateNxt),
      .xferType (typeNxt),
      .memrN    (memrNxt),
      .memwN    (memwNxt),
      .iorN     (iorNxt),
      .iowN     (iowNxt)
   );

   // State, latched channel attributes and registered outputs
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state      <= SI;
         typeQ      <= 2'b00;
         modeQ      <= 2'b00;
         autoQ      <= 1'b0;
         eopSeen    <= 1'b0;
         hldaLost   <= 1'b0;
         activeCh   <= '0;
         HRQ        <= 1'b0;
         DACK       <= '0;
         AEN        <= 1'b0;
         ADSTB      <= 1'b0;
         MEMR_n     <= 1'b1;
         MEMW_n     <= 1'b1;
         IOR_n      <= 1'b1;
         IOW_n      <= 1'b1;
         addrUpdate <= 1'b0;
         TC         <= 1'b0;
         reloadReq  <= 1'b0;
      end else begin
         state      <= stateNxt;
         typeQ      <= typeNxt;
         modeQ      <= modeNxt;
         autoQ      <= autoNxt;
         eopSeen    <= eopNxt;
         hldaLost   <= hldaNxt;
         activeCh   <= chNxt;
         HRQ        <= (stateNxt != SI);
         DACK       <= dackNxt;
         AEN        <= xferNxt;
         ADSTB      <= (stateNxt == S1);
         MEMR_n     <= memrNxt;
         MEMW_n     <= memwNxt;
         IOR_n      <= iorNxt;
         IOW_n      <= iowNxt;
         addrUpdate <= (stateNxt == S4);
         TC         <= (stateNxt == S4) && lastXfer;
         reloadReq  <= (stateNxt == S4) && lastXfer && autoNxt;
      end
   end

endmodule

// File: doc/dma_timing_control.md
Name: dma_timing_control

Overview:
- Downstream of the priority encoder / rotating-priority stage in the 8237A DMA controller.
- Takes the winning channel and a "request pending" flag, and runs the HRQ/HLDA bus handshake.
- Sequences the 8237A transfer states SI, S0, S1, S2, S3, SW, S4.
- Drives DACK, AEN, ADSTB, the four command strobes, the address/count update strobe and TC.

Parameters:
NUM_CH, 4, number of DMA channels; the DACK output width.
CH_W, 2, width of the encoded channel number.
EXTENDED_WRITE, 0, when 1 the write strobe asserts from S2 instead of S3 (command register bit 5 behaviour).

Ports:
CLK  in  1  system clock.
RESET  in  1  asynchronous, active-high reset.
validDREQ  in  1  at least one unmasked, valid request is pending (from priority stage).
grantCh  in  CH_W  encoded winning channel (from priority stage); valid while validDREQ=1.
xferType  in  2  mode-register transfer type of grantCh: 00 verify, 01 write (I/O->mem), 10 read (mem->I/O), 11 illegal (treated as verify).
xferMode  in  2  mode-register mode of grantCh: 00 demand, 01 single, 10 block, 11 cascade (treated as single).
autoInit  in  1  auto-initialise bit of grantCh.
HLDA  in  1  hold acknowledge from CPU.
READY  in  1  slow-device ready; sampled in S3/SW.
EOP_n  in  1  external end-of-process, active low.
lastXfer  in  1  current word count of active channel is 0 (this transfer produces TC).
HRQ  out  1  hold request to CPU.
DACK  out  NUM_CH  one-hot acknowledge, active high (polarity applied in priority stage).
AEN  out  1  address enable.
ADSTB  out  1  upper-address strobe.
MEMR_n, MEMW_n, IOR_n, IOW_n  out  1 each  command strobes, active low.
addrUpdate  out  1  one-cycle pulse: increment/decrement current address, decrement count.
TC  out  1  one-cycle terminal-count pulse.
reloadReq  out  1  one-cycle pulse: reload base into current registers (TC with autoInit).
activeCh  out  CH_W  latched serviced channel.

Behaviour:
- Reset values: HRQ=0, DACK=0, AEN=0, ADSTB=0, all command strobes=1, addrUpdate=0, TC=0, reloadReq=0, activeCh=0, state=SI.
- RESET asserted mid-transfer forces these values immediately; no transfer completes.
- All outputs are registered and change on the clock edge of state entry.
- SI: idle. If validDREQ=1, go to S0 and set HRQ=1.
- S0: HRQ stays 1.
  - HLDA=1: go to S1; latch grantCh, xferType, xferMode, autoInit.
  - validDREQ=0 before HLDA: go to SI and set HRQ=0.
  - HLDA is never sampled in SI.
- S1: AEN=1, ADSTB=1, DACK[activeCh]=1. Next state S2.
- S2: ADSTB=0.
  - Read strobe: MEMR_n=0 for read, IOR_n=0 for write, none for verify.
  - If EXTENDED_WRITE=1, the write strobe also asserts here.
  - Next state S3.
- S3: write strobe asserted (IOW_n for read, MEMW_n for write).
  - READY=0: go to SW.
  - READY=1: go to S4.
- SW: strobes held. Stays in SW while READY=0; goes to S4 when READY=1.
- S4:
  - All command strobes deassert.
  - addrUpdate=1.
  - TC=1 if lastXfer=1.
  - reloadReq=1 if lastXfer=1 and autoInit=1.
- Termination: endFlag = TC, or EOP_n=0 sampled in any of S1..S4/SW.
  - EOP_n low never aborts mid-cycle; the current transfer always completes through S4.
- Exit from S4:
  - endFlag, or single mode: go to SI; HRQ, DACK, AEN return to reset values on SI entry.
  - Demand mode: validDREQ=1 with grantCh==activeCh goes to S1; otherwise SI.
  - Block mode: go to S1 regardless of validDREQ.
- Channel changes on grantCh while not in S0 are ignored.
- Verify transfers run full timing with no strobes.
- HLDA dropping during S1..S4 is a protocol error. The block completes the current cycle, then goes to SI.

Decomposition:
- DmaPackage additions:
  - state enum: SI, S0, S1, S2, S3, SW, S4.
  - xfer type enum: VERIFY, WRITE, READ.
  - mode enum: DEMAND, SINGLE, BLOCK, CASCADE.
  - constants NUM_CH and CH_W.
- One combinational sub-module, dma_strobe_decode: (state, xferType, EXTENDED_WRITE) -> next values of MEMR_n/MEMW_n/IOR_n/IOW_n.

Test Plan:
1. Single read, ch2: validDREQ=1, grantCh=2, xferType=10, xferMode=01, HLDA high 2 cycles after HRQ.
   - Expect HRQ at cycle 1, S1 with DACK=0100 and AEN=1.
   - Expect MEMR_n=0 in S2, MEMR_n=0 and IOW_n=0 in S3.
   - Expect addrUpdate pulse in S4, then SI with HRQ=0.
2. Write with READY=0 for 3 cycles: IOR_n and MEMW_n held low through 3 SW cycles; S4 occurs on the 4th cycle after S3.
3. Block mode, lastXfer=1 on the 3rd transfer:
   - Expect three S1..S4 loops with no SI between them.
   - Expect TC=1 on the 3rd S4, then SI.
   - With autoInit=1, reloadReq pulses with TC.
4. Demand mode, validDREQ drops after the 2nd transfer: exactly 2 addrUpdate pulses, then SI, HRQ=0.
5. EOP_n low in S2 of a block transfer: the cycle completes (S3, S4, addrUpdate=1, TC=0), then SI.
6. RESET asserted in S3: all outputs return to reset values asynchronously with no addrUpdate. After release, validDREQ=1 with no HLDA keeps the block in S0; dropping validDREQ returns it to SI.
